// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory controller between an
// instruction-fetch port (read only) and a data port (read/write).
module mem_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_done,
   output logic [31:0] m1_rdata,
   output logic        resp_err,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_error,
   input  logic        mem_busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic          r_owner, r_last, r_we, r_err;
   logic [31:0]   r_addr, r_wdata, r_m0_rdata, r_m1_rdata;
   logic          w_start, w_pick, w_timeout, w_act, w_fin;

   assign w_start   = m0_req | m1_req;
   assign w_pick    = (m0_req & m1_req) ? ~r_last : m1_req;
   assign w_timeout = mem_busy && (r_cnt == CW'(TIMEOUT - 1));
   // w_fin: the cycle whose closing edge loads the response registers
   assign w_fin     = (r_state == CAPTURE) || (r_state == ISSUE && w_timeout);
   assign w_act     = (r_state == ISSUE) || (r_state == CAPTURE);

   always_ff @(posedge clk)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_start ? ISSUE : IDLE;
         ISSUE:   w_next = !mem_busy ? CAPTURE : (w_timeout ? RESP : ISSUE);
         CAPTURE: w_next = RESP;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_owner    <= 1'b0;
         r_last     <= 1'b1;
         r_we       <= 1'b0;
         r_err      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
      end else begin
         if (r_state == IDLE && w_start) begin
            r_owner <= w_pick;
            r_we    <= w_pick & m1_we;
            r_addr  <= w_pick ? m1_addr : m0_addr;
            r_wdata <= m1_wdata;
            r_cnt   <= '0;
         end
         if (r_state == ISSUE && mem_busy && !w_timeout) r_cnt <= r_cnt + 1'b1;
         if (w_fin) begin
            r_err <= (r_state == CAPTURE) ? mem_error : 1'b1;
            if (!r_owner)  r_m0_rdata <= (r_state == CAPTURE) ? mem_rdata : '0;
            else if (!r_we) r_m1_rdata <= (r_state == CAPTURE) ? mem_rdata : '0;
         end
         if (r_state == RESP) r_last <= r_owner;
      end
   end

   assign m0_gnt    = (r_state == ISSUE) && (r_cnt == '0) && !r_owner;
   assign m1_gnt    = (r_state == ISSUE) && (r_cnt == '0) && r_owner;
   assign m0_rvalid = (r_state == RESP) && !r_owner;
   assign m1_done   = (r_state == RESP) && r_owner;
   assign resp_err  = (r_state == RESP) && r_err;
   assign mem_rd    = w_act && !r_we;
   assign mem_wr    = w_act && r_we;
   assign mem_addr  = w_act ? r_addr : '0;
   assign mem_wdata = w_act ? r_wdata : '0;
   assign m0_rdata  = r_m0_rdata;
   assign m1_rdata  = r_m1_rdata;
endmodule
